// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared FSM state encoding and legal coin values for the vending controller
package vending_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CREDIT = 2'd1;
  localparam state_t ST_VEND   = 2'd2;
  localparam state_t ST_CHANGE = 2'd3;

  localparam logic [5:0] COIN_5  = 6'd5;
  localparam logic [5:0] COIN_10 = 6'd10;
  localparam logic [5:0] COIN_20 = 6'd20;

  function automatic logic coin_legal(input logic [5:0] val);
    return (val == COIN_5) || (val == COIN_10) || (val == COIN_20);
  endfunction

endpackage

// File: rtl/vending_controller_multi_if.sv
// rtl/vending_controller_multi_if.sv - coin/select/vend/change bus; sold_out exists only with VENDING_STOCK_TRACK_EN
interface vending_controller_multi_if #(
  parameter int N_PROD   = 4,
  parameter int CREDIT_W = 8
);
  localparam int IDX_W = $clog2(N_PROD);

  logic                       coin_valid;
  logic [5:0]                 coin_val;
  logic                       sel_valid;
  logic [IDX_W-1:0]           sel_idx;
  logic                       cancel;
  logic [N_PROD*CREDIT_W-1:0] price_tbl;
  logic                       restock;
  logic                       vend_valid;
  logic [IDX_W-1:0]           vend_idx;
  logic                       vend_ready;
  logic                       chg_valid;
  logic [CREDIT_W-1:0]        chg_amt;
  logic                       chg_ready;
  logic                       coin_rej;
  logic [CREDIT_W-1:0]        credit;
`ifdef VENDING_STOCK_TRACK_EN
  logic [N_PROD-1:0]          sold_out;
`endif

  modport master (
    output coin_valid, coin_val, sel_valid, sel_idx, cancel, price_tbl, restock, vend_ready, chg_ready,
`ifdef VENDING_STOCK_TRACK_EN
    input  sold_out,
`endif
    input  vend_valid, vend_idx, chg_valid, chg_amt, coin_rej, credit
  );

  modport slave (
    input  coin_valid, coin_val, sel_valid, sel_idx, cancel, price_tbl, restock, vend_ready, chg_ready,
`ifdef VENDING_STOCK_TRACK_EN
    output sold_out,
`endif
    output vend_valid, vend_idx, chg_valid, chg_amt, coin_rej, credit
  );

endinterface

// File: rtl/vending_stock_bank.sv
// rtl/vending_stock_bank.sv - per-product saturating stock counters with restock and sold_out flags
module vending_stock_bank #(
  parameter int N_PROD  = 4,
  parameter int STOCK_W = 4,
  parameter int IDX_W   = $clog2(N_PROD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dec,
  input  logic [IDX_W-1:0]  i_dec_idx,
  input  logic              i_restock,
  output logic [N_PROD-1:0] o_sold_out
);

  for (genvar k = 0; k < N_PROD; k++) begin : g_ctr
    logic [STOCK_W-1:0] r_stock;

    // The floor guard keeps a counter at zero even if a decrement slips through.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_stock <= '1;
      end else if (i_restock) begin
        r_stock <= '1;
      end else if (i_dec && (i_dec_idx == IDX_W'(k)) && (r_stock != '0)) begin
        r_stock <= r_stock - STOCK_W'(1);
      end
    end

    assign o_sold_out[k] = (r_stock == '0);
  end

endmodule

// File: rtl/vending_controller_multi.sv
// rtl/vending_controller_multi.sv - multi-product vending FSM; stock tracking enabled by VENDING_STOCK_TRACK_EN
module vending_controller_multi
  import vending_pkg::*;
#(
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_W    = 4
) (
  input logic                  clk,
  input logic                  rst,
  vending_controller_multi_if.slave bus
);

  localparam int                IDX_W = $clog2(N_PROD);
  localparam logic [CREDIT_W:0] W_MAX = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [IDX_W-1:0]    r_vend_idx;
  logic                r_coin_rej;

  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_price;
  logic                w_idx_ok;
  logic                w_in_stock;
  logic                w_cancel;
  logic                w_sel_ok;
  logic                w_coin_ok;
  logic                w_vend_hs;
  logic                w_chg_hs;

  assign w_sum    = {1'b0, r_credit} + (CREDIT_W+1)'(bus.coin_val);
  assign w_price  = bus.price_tbl[int'(bus.sel_idx)*CREDIT_W +: CREDIT_W];
  assign w_idx_ok = int'(bus.sel_idx) < N_PROD;

`ifdef VENDING_STOCK_TRACK_EN
  logic [N_PROD-1:0] w_sold_out;

  vending_stock_bank #(
    .N_PROD  (N_PROD),
    .STOCK_W (STOCK_W),
    .IDX_W   (IDX_W)
  ) u_stock (
    .clk        (clk),
    .rst        (rst),
    .i_dec      (w_vend_hs),
    .i_dec_idx  (r_vend_idx),
    .i_restock  (bus.restock && (r_state == ST_IDLE)),
    .o_sold_out (w_sold_out)
  );

  assign w_in_stock   = !w_sold_out[bus.sel_idx];
  assign bus.sold_out = w_sold_out;
`else
  logic w_unused;
  assign w_unused   = bus.restock;
  assign w_in_stock = 1'b1;
`endif

  // Within CREDIT, cancel beats a valid selection, which beats a coin.
  assign w_cancel  = (r_state == ST_CREDIT) && bus.cancel;
  assign w_sel_ok  = (r_state == ST_CREDIT) && bus.sel_valid && w_idx_ok &&
                     (r_credit >= w_price) && w_in_stock && !bus.cancel;
  assign w_coin_ok = bus.coin_valid && ((r_state == ST_IDLE) || (r_state == ST_CREDIT)) &&
                     coin_legal(bus.coin_val) && (w_sum <= W_MAX) && !w_cancel && !w_sel_ok;
  assign w_vend_hs = (r_state == ST_VEND) && bus.vend_ready;
  assign w_chg_hs  = (r_state == ST_CHANGE) && bus.chg_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_vend_idx <= '0;
      r_coin_rej <= 1'b0;
    end else begin
      r_coin_rej <= bus.coin_valid && !w_coin_ok;
      case (r_state)
        ST_IDLE: begin
          if (w_coin_ok) begin
            r_credit <= w_sum[CREDIT_W-1:0];
            r_state  <= ST_CREDIT;
          end
        end
        ST_CREDIT: begin
          if (w_cancel) begin
            r_state <= ST_CHANGE;
          end else if (w_sel_ok) begin
            r_vend_idx <= bus.sel_idx;
            r_credit   <= r_credit - w_price;
            r_state    <= ST_VEND;
          end else if (w_coin_ok) begin
            r_credit <= w_sum[CREDIT_W-1:0];
          end
        end
        ST_VEND: begin
          if (w_vend_hs) begin
            r_state <= (r_credit != '0) ? ST_CHANGE : ST_IDLE;
          end
        end
        ST_CHANGE: begin
          if (w_chg_hs) begin
            r_credit <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vend_valid = (r_state == ST_VEND);
  assign bus.vend_idx   = r_vend_idx;
  assign bus.chg_valid  = (r_state == ST_CHANGE);
  assign bus.chg_amt    = (r_state == ST_CHANGE) ? r_credit : '0;
  assign bus.coin_rej   = r_coin_rej;
  assign bus.credit     = r_credit;

endmodule

// File: tb/tb_vending_controller_multi.sv
// tb/tb_vending_controller_multi.sv - scoreboard bench for vending_controller_multi; stock scenario needs VENDING_STOCK_TRACK_EN
module tb_vending_controller_multi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [1:0] exp_vend[$];
  logic [7:0] exp_chg[$];

  always #5 clk = ~clk;

  vending_controller_multi_if #(.N_PROD(4), .CREDIT_W(8)) bus ();

  vending_controller_multi #(
    .N_PROD(4), .CREDIT_W(8), .MAX_CREDIT(100), .STOCK_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard: every handshake pops the oldest expectation pushed by the stimulus.
  task automatic tick();
    logic [1:0] ev;
    logic [7:0] ec;
    @(negedge clk);
    if (rst) begin
      if (bus.vend_valid || bus.chg_valid) begin
        checks++;
        if (bus.vend_valid && bus.chg_valid) begin
          errors++; $display("FAIL valid_exclusive vend_valid=%b chg_valid=%b required not both", bus.vend_valid, bus.chg_valid);
        end
      end
      if (bus.vend_valid && bus.vend_ready) begin
        checks++;
        if (exp_vend.size() == 0) begin
          errors++; $display("FAIL vend_unexpected vend_idx=%0d required no vend", bus.vend_idx);
        end else begin
          ev = exp_vend.pop_front();
          if (bus.vend_idx !== ev) begin
            errors++; $display("FAIL vend_idx got=%0d required=%0d", bus.vend_idx, ev);
          end
        end
      end
      if (bus.chg_valid && bus.chg_ready) begin
        checks++;
        if (exp_chg.size() == 0) begin
          errors++; $display("FAIL chg_unexpected chg_amt=%0d required no change", bus.chg_amt);
        end else begin
          ec = exp_chg.pop_front();
          if (bus.chg_amt !== ec) begin
            errors++; $display("FAIL chg_amt got=%0d required=%0d", bus.chg_amt, ec);
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic put_coin(input logic [5:0] v);
    bus.coin_valid = 1'b1; bus.coin_val = v; tick(); bus.coin_valid = 1'b0; bus.coin_val = '0;
  endtask

  task automatic press(input logic [1:0] k);
    bus.sel_valid = 1'b1; bus.sel_idx = k; tick(); bus.sel_valid = 1'b0; bus.sel_idx = '0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
  endtask

  task automatic take_vend();
    bus.vend_ready = 1'b1; tick(); bus.vend_ready = 1'b0;
  endtask

  task automatic take_chg();
    bus.chg_ready = 1'b1; tick(); bus.chg_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.coin_valid = 1'b1; bus.coin_val = 6'd20;
    tick(); tick();
    checks++;
    if ({bus.vend_valid, bus.vend_idx, bus.chg_valid, bus.chg_amt, bus.coin_rej, bus.credit} !== '0) begin
      errors++; $display("FAIL reset_outputs vv=%b vi=%0d cv=%b ca=%0d rej=%b credit=%0d required all 0",
                         bus.vend_valid, bus.vend_idx, bus.chg_valid, bus.chg_amt, bus.coin_rej, bus.credit);
    end
`ifdef VENDING_STOCK_TRACK_EN
    checks++;
    if (bus.sold_out !== 4'b0000) begin errors++; $display("FAIL reset_sold_out got=%b required=0000", bus.sold_out); end
`endif
    bus.coin_valid = 1'b0; bus.coin_val = '0;
    rst = 1'b1; tick();
  endtask

  task automatic test_basic_vend();
    put_coin(6'd20);
    checks++; if (bus.credit !== 8'd20) begin errors++; $display("FAIL basic_first_coin credit=%0d required=20", bus.credit); end
    put_coin(6'd20); put_coin(6'd10);
    checks++; if (bus.credit !== 8'd50) begin errors++; $display("FAIL basic_credit credit=%0d required=50", bus.credit); end
    exp_vend.push_back(2'd1); exp_chg.push_back(8'd5);
    press(2'd1);
    checks++;
    if ({bus.vend_valid, bus.vend_idx, bus.credit} !== {1'b1, 2'd1, 8'd5}) begin
      errors++; $display("FAIL basic_vend vv=%b vi=%0d credit=%0d required 1/1/5", bus.vend_valid, bus.vend_idx, bus.credit);
    end
    take_vend();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.vend_valid, bus.chg_valid, bus.chg_amt} !== {1'b0, 1'b1, 8'd5}) begin
        errors++; $display("FAIL basic_change_hold vv=%b cv=%b ca=%0d required 0/1/5", bus.vend_valid, bus.chg_valid, bus.chg_amt);
      end
      if (i < 2) tick();
    end
    take_chg();
    checks++;
    if ({bus.chg_valid, bus.credit} !== 9'd0) begin
      errors++; $display("FAIL basic_idle cv=%b credit=%0d required 0/0", bus.chg_valid, bus.credit);
    end
  endtask

  task automatic test_coin_reject();
    put_coin(6'd10);
    put_coin(6'd7);
    checks++;
    if ({bus.coin_rej, bus.credit} !== {1'b1, 8'd10}) begin
      errors++; $display("FAIL rej_illegal rej=%b credit=%0d required 1/10", bus.coin_rej, bus.credit);
    end
    tick();
    checks++; if (bus.coin_rej !== 1'b0) begin errors++; $display("FAIL rej_pulse_width rej=%b required=0", bus.coin_rej); end
    for (int i = 0; i < 4; i++) put_coin(6'd20);
    put_coin(6'd20);
    checks++;
    if ({bus.coin_rej, bus.credit} !== {1'b1, 8'd90}) begin
      errors++; $display("FAIL rej_over_max rej=%b credit=%0d required 1/90", bus.coin_rej, bus.credit);
    end
    put_coin(6'd10);
    checks++;
    if ({bus.coin_rej, bus.credit} !== {1'b0, 8'd100}) begin
      errors++; $display("FAIL accept_at_max rej=%b credit=%0d required 0/100", bus.coin_rej, bus.credit);
    end
    exp_chg.push_back(8'd100);
    do_cancel();
    put_coin(6'd5);
    checks++;
    if ({bus.coin_rej, bus.chg_valid, bus.chg_amt} !== {1'b1, 1'b1, 8'd100}) begin
      errors++; $display("FAIL rej_in_change rej=%b cv=%b ca=%0d required 1/1/100", bus.coin_rej, bus.chg_valid, bus.chg_amt);
    end
    take_chg();
  endtask

  task automatic test_select_ignored();
    press(2'd0);
    checks++;
    if ({bus.vend_valid, bus.credit} !== 9'd0) begin
      errors++; $display("FAIL sel_in_idle vv=%b credit=%0d required 0/0", bus.vend_valid, bus.credit);
    end
    put_coin(6'd10);
    press(2'd0);
    checks++;
    if ({bus.vend_valid, bus.chg_valid, bus.credit} !== {1'b0, 1'b0, 8'd10}) begin
      errors++; $display("FAIL sel_short_credit vv=%b cv=%b credit=%0d required 0/0/10", bus.vend_valid, bus.chg_valid, bus.credit);
    end
    exp_chg.push_back(8'd10);
    do_cancel();
    checks++;
    if ({bus.chg_valid, bus.chg_amt} !== {1'b1, 8'd10}) begin
      errors++; $display("FAIL cancel_change cv=%b ca=%0d required 1/10", bus.chg_valid, bus.chg_amt);
    end
    take_chg();
  endtask

  task automatic test_priority();
    put_coin(6'd20);
    exp_chg.push_back(8'd20);
    bus.cancel = 1'b1; bus.sel_valid = 1'b1; bus.sel_idx = 2'd0; bus.coin_valid = 1'b1; bus.coin_val = 6'd20;
    tick();
    bus.cancel = 1'b0; bus.sel_valid = 1'b0; bus.coin_valid = 1'b0; bus.coin_val = '0;
    checks++;
    if ({bus.chg_valid, bus.vend_valid, bus.coin_rej, bus.chg_amt} !== {1'b1, 1'b0, 1'b1, 8'd20}) begin
      errors++; $display("FAIL prio_cancel cv=%b vv=%b rej=%b ca=%0d required 1/0/1/20",
                         bus.chg_valid, bus.vend_valid, bus.coin_rej, bus.chg_amt);
    end
    take_chg();
    put_coin(6'd20);
    exp_vend.push_back(2'd0); exp_chg.push_back(8'd5);
    bus.sel_valid = 1'b1; bus.sel_idx = 2'd0; bus.coin_valid = 1'b1; bus.coin_val = 6'd5;
    tick();
    bus.sel_valid = 1'b0; bus.coin_valid = 1'b0; bus.coin_val = '0;
    checks++;
    if ({bus.vend_valid, bus.coin_rej, bus.credit} !== {1'b1, 1'b1, 8'd5}) begin
      errors++; $display("FAIL prio_sel_over_coin vv=%b rej=%b credit=%0d required 1/1/5", bus.vend_valid, bus.coin_rej, bus.credit);
    end
    take_vend(); take_chg();
  endtask

  task automatic test_vend_hold();
    put_coin(6'd20); put_coin(6'd10);
    exp_vend.push_back(2'd2);
    press(2'd2);
    for (int i = 0; i < 5; i++) begin
      bus.cancel = (i == 2);
      tick();
      checks++;
      if ({bus.vend_valid, bus.vend_idx, bus.chg_valid} !== {1'b1, 2'd2, 1'b0}) begin
        errors++; $display("FAIL vend_hold cycle=%0d vv=%b vi=%0d cv=%b required 1/2/0", i, bus.vend_valid, bus.vend_idx, bus.chg_valid);
      end
    end
    bus.cancel = 1'b0;
    take_vend();
    checks++;
    if ({bus.vend_valid, bus.chg_valid, bus.credit} !== 10'd0) begin
      errors++; $display("FAIL vend_exact_to_idle vv=%b cv=%b credit=%0d required 0/0/0", bus.vend_valid, bus.chg_valid, bus.credit);
    end
    put_coin(6'd20); put_coin(6'd20);
    exp_vend.push_back(2'd2); exp_chg.push_back(8'd10);
    press(2'd2);
    tick();
    rst = 1'b0; tick(); rst = 1'b1;
    exp_vend.delete(); exp_chg.delete();
    tick();
    checks++;
    if ({bus.vend_valid, bus.chg_valid, bus.credit} !== 10'd0) begin
      errors++; $display("FAIL reset_mid_vend vv=%b cv=%b credit=%0d required 0/0/0", bus.vend_valid, bus.chg_valid, bus.credit);
    end
    put_coin(6'd5);
    checks++; if (bus.credit !== 8'd5) begin errors++; $display("FAIL post_reset_coin credit=%0d required=5", bus.credit); end
    exp_chg.push_back(8'd5);
    do_cancel(); take_chg();
  endtask

  task automatic test_stock();
`ifdef VENDING_STOCK_TRACK_EN
    bus.restock = 1'b1; tick(); bus.restock = 1'b0;
    checks++; if (bus.sold_out !== 4'b0000) begin errors++; $display("FAIL stock_restock_idle sold_out=%b required=0000", bus.sold_out); end
    for (int i = 0; i < 3; i++) begin
      put_coin(6'd20);
      exp_vend.push_back(2'd0); exp_chg.push_back(8'd5);
      press(2'd0); take_vend(); take_chg();
    end
    checks++; if (bus.sold_out !== 4'b0001) begin errors++; $display("FAIL stock_sold_out sold_out=%b required=0001", bus.sold_out); end
    put_coin(6'd20);
    press(2'd0);
    checks++;
    if ({bus.vend_valid, bus.credit} !== {1'b0, 8'd20}) begin
      errors++; $display("FAIL stock_empty_select vv=%b credit=%0d required 0/20", bus.vend_valid, bus.credit);
    end
    bus.restock = 1'b1; tick(); bus.restock = 1'b0;
    checks++; if (bus.sold_out !== 4'b0001) begin errors++; $display("FAIL stock_restock_credit sold_out=%b required=0001", bus.sold_out); end
    exp_chg.push_back(8'd20);
    do_cancel(); take_chg();
    bus.restock = 1'b1; tick(); bus.restock = 1'b0;
    checks++; if (bus.sold_out !== 4'b0000) begin errors++; $display("FAIL stock_refill sold_out=%b required=0000", bus.sold_out); end
`else
    for (int i = 0; i < 4; i++) begin
      put_coin(6'd20);
      exp_vend.push_back(2'd0); exp_chg.push_back(8'd5);
      press(2'd0);
      checks++;
      if ({bus.vend_valid, bus.credit} !== {1'b1, 8'd5}) begin
        errors++; $display("FAIL unlimited_stock vend=%0d vv=%b credit=%0d required 1/5", i, bus.vend_valid, bus.credit);
      end
      take_vend(); take_chg();
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.coin_valid = 1'b0; bus.coin_val = '0; bus.sel_valid = 1'b0; bus.sel_idx = '0;
    bus.cancel = 1'b0; bus.restock = 1'b0; bus.vend_ready = 1'b0; bus.chg_ready = 1'b0;
    bus.price_tbl = {8'd100, 8'd30, 8'd45, 8'd15};
    test_reset();
    test_basic_vend();
    test_coin_reject();
    test_select_ignored();
    test_priority();
    test_vend_hold();
    test_stock();
    checks++;
    if (exp_vend.size() + exp_chg.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain pending_vend=%0d pending_chg=%0d required 0/0", exp_vend.size(), exp_chg.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vending_controller_multi.md
VENDING_CONTROLLER_MULTI -- requirements
Module: vending_controller_multi

Interface
REQ-001 Parameter N_PROD, default 4: number of products; the legal range is 2..16.
REQ-002 Parameter CREDIT_W, default 8: width of the credit, price and change fields.
REQ-003 Parameter MAX_CREDIT, default 100: the highest credit the block accepts.
REQ-004 Parameter STOCK_W, default 4: width of the per-product stock counter; full stock is 2^STOCK_W-1.
REQ-005 clk  in  1  clock; all logic acts on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 coin_valid  in  1  a coin is presented this cycle.
REQ-008 coin_val  in  6  coin value in cents; only 5, 10 and 20 are legal.
REQ-009 sel_valid  in  1  a product selection is presented this cycle.
REQ-010 sel_idx  in  $clog2(N_PROD)  the selected product index.
REQ-011 cancel  in  1  request to refund the current credit.
REQ-012 price_tbl  in  N_PROD*CREDIT_W  price of product k in slice [k*CREDIT_W +: CREDIT_W]; static during operation.
REQ-013 restock  in  1  request to refill all stock counters.
REQ-014 vend_valid/vend_idx  out  1/$clog2(N_PROD)  product release request and the index to release.
REQ-015 vend_ready  in  1  the dispenser accepts the vend.
REQ-016 chg_valid/chg_amt  out  1/CREDIT_W  change payout request and the amount to pay out.
REQ-017 chg_ready  in  1  the payout mechanism accepts the change.
REQ-018 coin_rej  out  1  one-cycle pulse: the presented coin is returned.
REQ-019 credit  out  CREDIT_W  current registered credit.

Function
REQ-020 The FSM SHALL have four states: IDLE, CREDIT, VEND and CHANGE.
REQ-021 In IDLE or CREDIT, a legal coin where credit+coin_val <= MAX_CREDIT SHALL add coin_val to credit on the next edge and move IDLE to CREDIT.
REQ-022 An illegal coin, a coin that would exceed MAX_CREDIT, or any coin presented in VEND or CHANGE SHALL pulse coin_rej for one cycle on the next cycle and leave credit unchanged.
REQ-023 In CREDIT, sel_valid with sel_idx < N_PROD, credit >= price, and stock > 0 SHALL do all of the following on the next edge: register vend_idx, subtract the price from credit, and enter VEND.
REQ-024 Any other selection SHALL be ignored, including a selection made in IDLE.
REQ-025 Same-cycle priority in CREDIT SHALL be cancel > accepted sel > coin; a coin that loses to cancel or to an accepted sel SHALL be rejected per REQ-022.
REQ-026 In VEND, vend_valid=1 and vend_idx SHALL be held stable until vend_ready is seen; on that handshake edge:
- the selected stock counter decrements by 1;
- the next state is CHANGE if credit > 0, else IDLE.
REQ-027 cancel in CREDIT SHALL move the FSM to CHANGE; cancel in any other state SHALL be ignored.
REQ-028 In CHANGE, chg_valid=1 and chg_amt=credit SHALL be held until chg_ready is seen; on that handshake edge credit clears to 0 and the FSM moves to IDLE.
REQ-029 vend_valid and chg_valid SHALL never be asserted at the same time.
REQ-030 restock SHALL set every stock counter to full only in IDLE, and SHALL be ignored in any other state.
REQ-031 Stock counters SHALL never wrap below 0; a product with stock 0 cannot be selected.

Reset
REQ-032 While rst=0, the block SHALL force:
- state to IDLE;
- credit, vend_valid, vend_idx, chg_valid, chg_amt and coin_rej to 0;
- every stock counter to full.
REQ-033 Asserting reset mid-vend or mid-change SHALL discard the pending credit, with no payout.

Configuration
REQ-034 The macro VENDING_STOCK_TRACK_EN SHALL control stock tracking.
- Defined: the stock counters, restock, and an extra output sold_out[N_PROD] SHALL be present; sold_out[k]=1 exactly when stock k is 0.
- Undefined: there SHALL be no stock counters, stock is treated as unlimited, restock is ignored, and sold_out is absent.

Structure
REQ-035 A shared package vending_pkg SHALL hold the FSM state enum and the legal coin constants (COIN_5, COIN_10, COIN_20).
REQ-036 A sub-module vending_stock_bank SHALL hold the N_PROD stock counters, the decrement and restock logic, and sold_out.

Verification
REQ-037 Reset, coin 20, 20, 10, select product 1 priced 45, then vend_ready -> credit 50, vend_idx=1, then chg_amt=5 until chg_ready, then IDLE.
REQ-038 Coin 7 in CREDIT -> coin_rej pulse, credit unchanged; with credit 90, coin 20 -> coin_rej.
REQ-039 Credit 10, select product priced 15 -> ignored, still CREDIT; then cancel -> chg_amt=10.
REQ-040 cancel, sel and coin in the same cycle with credit 20 -> CHANGE, coin_rej=1, chg_amt=20.
REQ-041 Under VENDING_STOCK_TRACK_EN, STOCK_W=2: three vends of product 0 -> sold_out[0]=1 and a fourth select is ignored; restock in IDLE -> sold_out[0]=0.
REQ-042 Hold vend_ready=0 for 5 cycles during VEND -> vend_valid and vend_idx stay stable; reset mid-VEND -> IDLE, credit 0.
